// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forward-select codes, load result code and the memory-wait FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic {
    S_RUN,
    S_WAIT
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_p.sv
// Pipeline hazard controller: forwarding, load-use/RAW stalls,
// memory wait-state freeze, wait timeout and perf counters.
module hazard_ctrl_p
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              lwStall,
  output logic              MemTimeout,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] waitCnt;
  logic [31:0]   runLen;
  logic          memStall;
  logic          hazD;
  logic          loadUse;

  function automatic logic hit(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd,
    input logic              we
  );
    return we && (rs != '0) && (rs == rd);
  endfunction

  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] rs
  );
    if (hit(rs, RdM, RegWriteM)) return FWD_M;
    if (hit(rs, RdW, RegWriteW)) return FWD_W;
    return FWD_RF;
  endfunction

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (FWD_EN != 0) begin
      ForwardAE = fwdSel(Rs1E);
      ForwardBE = fwdSel(Rs2E);
    end
  end

  assign hazD = hit(Rs1D, RdE, RegWriteE)
              | hit(Rs2D, RdE, RegWriteE)
              | hit(Rs1D, RdM, RegWriteM)
              | hit(Rs2D, RdM, RegWriteM);

  assign loadUse = (ResultSrcE == RES_LOAD)
                 & (hit(Rs1D, RdE, 1'b1)
                 |  hit(Rs2D, RdE, 1'b1));

  assign lwStall  = (FWD_EN != 0) ? loadUse : hazD;
  assign memStall = MemReqM & ~MemReadyM;

  // Conditions overlap, so first match wins.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    priority case (1'b1)
      memStall: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end
      PCSrcE: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      lwStall: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      default: ;
    endcase
  end

  // Length of the current wait run including this cycle.
  assign runLen = (state == S_WAIT) ? (32'(waitCnt) + 32'd2) : 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      waitCnt    <= '0;
      MemTimeout <= 1'b0;
    end else begin
      unique case (state)
        S_RUN: begin
          waitCnt <= '0;
          if (memStall) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!memStall) begin
            state   <= S_RUN;
            waitCnt <= '0;
          end else if (waitCnt != CW'(MEM_TIMEOUT)) begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: state <= S_RUN;
      endcase
      if (memStall && (runLen >= 32'(MEM_TIMEOUT))) begin
        MemTimeout <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (StallF),
    .count (StallCount)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (FlushD),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Scoreboard bench: two hazard_ctrl_p builds (forwarding on / off)
// share one stimulus stream and are checked against a reference model.
module tb_hazard_ctrl_p;

  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    bit         weE, weM, weW;
    logic [1:0] resE;
    bit         pc, req, rdy;
  } stim_t;

  typedef struct {
    logic [1:0] fa, fb;
    bit         sF, sD, sE, sM, fD, fE, fW, lw, tmo;
    int         sc, fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0;
  logic [4:0] RdE = '0, RdM = '0, RdW = '0;
  logic       RegWriteE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
  logic [1:0] ResultSrcE = '0;
  logic       PCSrcE = 1'b0, MemReqM = 1'b0, MemReadyM = 1'b0;

  logic [1:0] fa [2];
  logic [1:0] fb [2];
  logic       sF [2], sD [2], sE [2], sM [2];
  logic       fD [2], fE [2], fW [2], lw [2], tmo [2];
  logic [15:0] scA, fcA;
  logic [1:0]  scB, fcB;

  int checks = 0;
  int fails  = 0;

  exp_t qA[$];
  exp_t qB[$];

  int run [2];
  int sc  [2];
  int fc  [2];
  bit tm  [2];
  int mt  [2] = '{4, 3};
  int cmx [2] = '{65535, 3};

  always #5 clk = ~clk;

  hazard_ctrl_p #(
    .REG_AW(5), .FWD_EN(1), .MEM_TIMEOUT(4), .CNT_W(16)
  ) dutA (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(fa[0]), .ForwardBE(fb[0]),
    .StallF(sF[0]), .StallD(sD[0]), .StallE(sE[0]), .StallM(sM[0]),
    .FlushD(fD[0]), .FlushE(fE[0]), .FlushW(fW[0]),
    .lwStall(lw[0]), .MemTimeout(tmo[0]),
    .StallCount(scA), .FlushCount(fcA)
  );

  hazard_ctrl_p #(
    .REG_AW(5), .FWD_EN(0), .MEM_TIMEOUT(3), .CNT_W(2)
  ) dutB (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(fa[1]), .ForwardBE(fb[1]),
    .StallF(sF[1]), .StallD(sD[1]), .StallE(sE[1]), .StallM(sM[1]),
    .FlushD(fD[1]), .FlushE(fE[1]), .FlushW(fW[1]),
    .lwStall(lw[1]), .MemTimeout(tmo[1]),
    .StallCount(scB), .FlushCount(fcB)
  );

  function automatic bit same(logic [4:0] rs, logic [4:0] rd);
    return (rs != 5'd0) && (rs == rd);
  endfunction

  function automatic logic [1:0] refFwd(stim_t s, logic [4:0] rs);
    if (s.weM && same(rs, s.rdM)) return 2'b10;
    if (s.weW && same(rs, s.rdW)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t refComb(stim_t s, bit fwd);
    exp_t e;
    bit useE, useM;
    e = '{default: 0};
    useE = same(s.rs1D, s.rdE) || same(s.rs2D, s.rdE);
    useM = same(s.rs1D, s.rdM) || same(s.rs2D, s.rdM);
    if (fwd) begin
      e.fa = refFwd(s, s.rs1E);
      e.fb = refFwd(s, s.rs2E);
      e.lw = (s.resE == 2'b01) && useE;
    end else begin
      e.lw = (s.weE && useE) || (s.weM && useM);
    end
    if (s.req && !s.rdy) begin
      {e.sF, e.sD, e.sE, e.sM, e.fW} = 5'b11111;
    end else if (s.pc) begin
      {e.fD, e.fE} = 2'b11;
    end else if (e.lw) begin
      {e.sF, e.sD, e.fE} = 3'b111;
    end
    return e;
  endfunction

  task automatic step(stim_t s, bit rst);
    exp_t e [2];
    @(posedge clk);
    #1;
    Rs1D = s.rs1D; Rs2D = s.rs2D; Rs1E = s.rs1E; Rs2E = s.rs2E;
    RdE = s.rdE; RdM = s.rdM; RdW = s.rdW;
    RegWriteE = s.weE; RegWriteM = s.weM; RegWriteW = s.weW;
    ResultSrcE = s.resE; PCSrcE = s.pc;
    MemReqM = s.req; MemReadyM = s.rdy;
    rst_n = !rst;
    for (int i = 0; i < 2; i++) begin
      e[i] = refComb(s, i == 0);
      if (rst) begin
        run[i] = 0; sc[i] = 0; fc[i] = 0; tm[i] = 0;
      end
      e[i].sc = sc[i];
      e[i].fc = fc[i];
      e[i].tmo = tm[i];
      if (!rst) begin
        if (e[i].sF && sc[i] < cmx[i]) sc[i]++;
        if (e[i].fD && fc[i] < cmx[i]) fc[i]++;
        run[i] = (s.req && !s.rdy) ? run[i] + 1 : 0;
        if (run[i] >= mt[i]) tm[i] = 1;
      end
    end
    qA.push_back(e[0]);
    qB.push_back(e[1]);
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(int i, exp_t e);
    string p;
    p = (i == 0) ? "fwd" : "nofwd";
    chk({p, ".ForwardAE"}, int'(fa[i]), int'(e.fa));
    chk({p, ".ForwardBE"}, int'(fb[i]), int'(e.fb));
    chk({p, ".Stalls"}, int'({sF[i], sD[i], sE[i], sM[i]}),
        int'({e.sF, e.sD, e.sE, e.sM}));
    chk({p, ".Flushes"}, int'({fD[i], fE[i], fW[i]}),
        int'({e.fD, e.fE, e.fW}));
    chk({p, ".lwStall"}, int'(lw[i]), int'(e.lw));
    chk({p, ".MemTimeout"}, int'(tmo[i]), int'(e.tmo));
    chk({p, ".StallCount"}, (i == 0) ? int'(scA) : int'(scB), e.sc);
    chk({p, ".FlushCount"}, (i == 0) ? int'(fcA) : int'(fcB), e.fc);
  endtask

  always @(negedge clk) begin
    if (qA.size() > 0) begin
      cmp(0, qA.pop_front());
      cmp(1, qB.pop_front());
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  initial begin
    stim_t s;
    bit holdReq;
    step(idle(), 1);
    step(idle(), 1);
    step(idle(), 0);

    s = idle();
    s.rdM = 5; s.rdW = 5; s.rs1E = 5; s.weM = 1; s.weW = 1;
    step(s, 0);
    s.weM = 0;
    step(s, 0);
    s.rs1E = 0;
    step(s, 0);

    s = idle();
    s.resE = 2'b01; s.rdE = 7; s.rs2D = 7; s.weE = 1;
    step(s, 0);
    s.rdE = 0;
    step(s, 0);

    s = idle();
    s.req = 1; s.pc = 1;
    repeat (3) step(s, 0);
    s.rdy = 1;
    step(s, 0);
    step(idle(), 0);

    s = idle();
    s.req = 1;
    repeat (4) step(s, 0);
    s.rdy = 1;
    step(s, 0);
    repeat (2) step(idle(), 0);
    step(idle(), 1);
    step(idle(), 0);

    s = idle();
    s.weM = 1; s.rdM = 3; s.rs1D = 3;
    step(s, 0);
    s.weM = 0; s.weW = 1; s.rdW = 3;
    step(s, 0);

    s = idle();
    s.weE = 1; s.rdE = 2; s.rs1D = 2;
    repeat (6) step(s, 0);

    holdReq = 0;
    for (int n = 0; n < 500; n++) begin
      s.rs1D = 5'($urandom_range(0, 3));
      s.rs2D = 5'($urandom_range(0, 3));
      s.rs1E = 5'($urandom_range(0, 3));
      s.rs2E = 5'($urandom_range(0, 3));
      s.rdE  = 5'($urandom_range(0, 3));
      s.rdM  = 5'($urandom_range(0, 3));
      s.rdW  = 5'($urandom_range(0, 3));
      s.weE  = 1'($urandom_range(0, 1));
      s.weM  = 1'($urandom_range(0, 1));
      s.weW  = 1'($urandom_range(0, 1));
      s.resE = 2'($urandom_range(0, 3));
      s.pc   = ($urandom_range(0, 5) == 0);
      s.req  = holdReq || ($urandom_range(0, 3) == 0);
      s.rdy  = ($urandom_range(0, 3) == 0);
      holdReq = s.req && !s.rdy;
      step(s, $urandom_range(0, 79) == 0);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard.drained", qA.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_p.md
# hazard_ctrl_p

Parametrised pipeline hazard controller for the five-stage RISC-V core; the next generation of the core's hazard unit. Adds three things to the combinational forwarding and load-use logic:
- a data-memory ready handshake that freezes the pipeline on wait states;
- a no-forwarding build mode that stalls on all RAW hazards;
- a memory-wait timeout flag and saturating stall/flush performance counters.

It sits beside the datapath and drives its stall, flush and forward-select inputs.

## Interface
Parameters:
- REG_AW, 5: register index width.
- FWD_EN, 1: 1 = E-stage forwarding enabled; 0 = forwarding disabled, RAW hazards resolved by stalling.
- MEM_TIMEOUT, 64: consecutive memory-wait cycles that set MemTimeout; must be ≥ 1.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Rs1D, Rs2D  in  REG_AW  source registers in Decode.
- Rs1E, Rs2E, RdE  in  REG_AW  sources and destination in Execute.
- RdM, RdW  in  REG_AW  destinations in Memory and Writeback.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage.
- ResultSrcE  in  2  result select in Execute; 2'b01 = load.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- MemReqM  in  1  load or store active in Memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 ResultW, 10 ALUResultM.
- StallF, StallD, StallE, StallM  out  1  hold the pipeline register feeding the named stage.
- FlushD, FlushE, FlushW  out  1  bubble into the named stage.
- lwStall  out  1  load-use (or RAW, when FWD_EN=0) stall active.
- MemTimeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT.
- StallCount, FlushCount  out  CNT_W  saturating event counters.

## Operation
- Register x0 never matches. Every comparison requires a nonzero source index.
- Forwarding (FWD_EN=1):
  - ForwardAE=10 if RegWriteM and RdM==Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW and RdW==Rs1E.
  - Otherwise 00. M has priority over W.
  - ForwardBE is identical, using Rs2E.
- FWD_EN=0:
  - Forward outputs are constant 00.
  - hazD = Rs1D or Rs2D matches RdE (with RegWriteE) or RdM (with RegWriteM).
  - W is not checked; the register file writes through.
- lwStall:
  - FWD_EN=1: ResultSrcE==01 and RdE matches Rs1D or Rs2D.
  - FWD_EN=0: lwStall = hazD.
- memStall = MemReqM & ~MemReadyM.
- Priority: memStall > PCSrcE > lwStall.
  - memStall: StallF, StallD, StallE and StallM are 1; FlushW=1; FlushD=0 and FlushE=0. A PCSrcE held during the wait is not acted on until the release cycle.
  - else PCSrcE: FlushD=1, FlushE=1, all stalls 0. A redirect overrides a coincident lwStall.
  - else lwStall: StallF=1, StallD=1, FlushE=1.
  - else: all 0.
- The lwStall output reflects the raw condition, independent of priority.
- FSM with states RUN and WAIT:
  - RUN→WAIT on a clock edge where memStall=1.
  - WAIT→RUN on an edge where MemReadyM=1 or MemReqM=0.
  - The wait counter is cleared in RUN and increments in WAIT.
  - When the count reaches MEM_TIMEOUT−1 in WAIT, MemTimeout is set. It stays set until reset; the pipeline keeps waiting.
- StallCount increments on every cycle with StallF=1. FlushCount increments on every cycle with FlushD=1. Both saturate at all-ones and do not wrap.

## Timing
- All stall, flush, forward and lwStall outputs are combinational, valid in the same cycle as their inputs. No added latency.
- Counters and MemTimeout update on the rising clk edge after the qualifying cycle.
- MemTimeout is first high after exactly MEM_TIMEOUT consecutive memStall cycles.
- Reset values (asynchronous, on rst_n low): FSM=RUN, wait counter 0, MemTimeout 0, StallCount 0, FlushCount 0.
- Combinational outputs track their inputs during reset.
- Reset asserted mid-wait returns to RUN immediately. After release, a still-asserted memStall re-enters WAIT with the count starting from 0.
- memStall asserted and released in the same cycle (MemReadyM=1): no stall, FSM stays in RUN.

## Structure
- Package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - RES_LOAD=2'b01;
  - the state enum {S_RUN, S_WAIT}.
- Sub-module sat_counter (parameter W; inputs clk, rst_n, inc; output count) is instantiated twice, once per performance counter.
- The wait counter is sized $clog2(MEM_TIMEOUT+1) and stays local.

## Test plan
- FWD_EN=1, RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 → ForwardAE=10. Drop RegWriteM → ForwardAE=01. Set Rs1E=0 → ForwardAE=00.
- ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1, lwStall=1. Next cycle, with RdE cleared, all deassert. StallCount=1.
- MemReqM=1, MemReadyM=0 for 3 cycles, with PCSrcE=1 throughout → StallF/D/E/M=1, FlushW=1, FlushD=0 for 3 cycles. On the MemReadyM=1 cycle, FlushD=FlushE=1. StallCount=3, FlushCount=1.
- MEM_TIMEOUT=4, memStall held 4 cycles → MemTimeout rises after the 4th edge and stays high after MemReadyM. A subsequent rst_n pulse clears it.
- FWD_EN=0, RegWriteM=1, RdM=3, Rs1D=3 → lwStall=1, ForwardAE=00, StallD=1. With RdW=3 instead → no stall.
- CNT_W=2, 5 consecutive lwStall cycles → StallCount reads 1, 2, 3, 3, 3.
